// File: rtl/wide_add_sequencer.sv
// Sequences W-bit additions through one 32-bit Kogge-Stone adder, one slice per cycle.
// Optional subtract mode is enabled with `define WIDE_ADD_SUB_EN (adds the sub port).

module ks_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_o,
    output logic p_o
);
    assign g_o = g_hi | (p_hi & g_lo);
    assign p_o = p_hi & p_lo;
endmodule

module n_bit_pg_Kogge_Stone_A #(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
);
    localparam int ST = $clog2(N);

    logic [ST:0][N-1:0] g;
    logic [ST:0][N-1:0] p;
    logic [N:0]         c;

    assign g[0] = A & B;
    assign p[0] = A ^ B;

    for (genvar s = 0; s < ST; s++) begin : g_stage
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= (1 << s)) begin : g_cell
                ks_cell u_cell (
                    .g_hi (g[s][i]),
                    .p_hi (p[s][i]),
                    .g_lo (g[s][i-(1<<s)]),
                    .p_lo (p[s][i-(1<<s)]),
                    .g_o  (g[s+1][i]),
                    .p_o  (p[s+1][i])
                );
            end else begin : g_pass
                assign g[s+1][i] = g[s][i];
                assign p[s+1][i] = p[s][i];
            end
        end
    end

    // Group (G,P) over bits i..0 folds in Cin to give the carry into bit i+1.
    assign c[0] = Cin;
    for (genvar i = 0; i < N; i++) begin : g_carry
        assign c[i+1] = g[ST][i] | (p[ST][i] & Cin);
    end

    assign S    = p[0] ^ c[N-1:0];
    assign Cout = c[N];
endmodule

module wide_add_sequencer #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int SLICES = W / 32;
    localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    if (W <= 0 || (W % 32) != 0) begin : g_w_check
        $error("wide_add_sequencer: W must be a positive multiple of 32");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic                     carry_q, carry_d;
    logic                     cout_q, cout_d;
    logic [SLICES-1:0][31:0]  a_q, a_d;
    logic [SLICES-1:0][31:0]  b_q, b_d;
    logic [SLICES-1:0][31:0]  sum_q, sum_d;

    logic [31:0] add_a, add_b, add_s;
    logic        add_co;

    assign add_a = a_q[k_q];
    assign add_b = b_q[k_q];

    n_bit_pg_Kogge_Stone_A #(.N(32)) u_adder (
        .A    (add_a),
        .B    (add_b),
        .Cin  (carry_q),
        .S    (add_s),
        .Cout (add_co)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    k_d     = '0;
`ifdef WIDE_ADD_SUB_EN
                    b_d     = sub ? ~b : b;
                    carry_d = sub | cin;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[k_q] = add_s;
                carry_d    = add_co;
                if (k_q == KW'(SLICES - 1)) begin
                    cout_d  = add_co;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    // in_ready is the only combinational output; it drops with rst.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (W=128): vector table plus backpressure and reset-abort sequences.

module tb_wide_add_sequencer;
    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int checks   = 0;
    int failures = 0;

    wide_add_sequencer #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef WIDE_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Caller sits 1ns after a rising edge; returns at the same phase.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic ts, output logic [W-1:0] rs, output logic rc,
                          output int lat);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_issue", W'(in_ready), W'(1));
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = '1; b = '1; cin = ~tc; sub = ~ts;
        wait_out(lat);
        rs = sum;
        rc = cout;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] rs;
        logic         rc;
        int           lat;
        vec_t         v;

        ones = '1;
        vq.push_back('{a: W'(1), b: ones, cin: 1'b0, sub: 1'b0, s: W'(0), co: 1'b1});
        vq.push_back('{a: W'(32'hFFFF_FFFF), b: W'(1), cin: 1'b0, sub: 1'b0,
                       s: W'(1) << 32, co: 1'b0});
        vq.push_back('{a: W'(0), b: W'(0), cin: 1'b1, sub: 1'b0, s: W'(1), co: 1'b0});
        vq.push_back('{a: ones, b: ones, cin: 1'b1, sub: 1'b0, s: ones, co: 1'b1});
        vq.push_back('{a: W'(1) << 127, b: W'(1) << 127, cin: 1'b0, sub: 1'b0,
                       s: W'(0), co: 1'b1});
        vq.push_back('{a: ones >> 32, b: W'(1), cin: 1'b0, sub: 1'b0,
                       s: W'(1) << 96, co: 1'b0});
        vq.push_back('{a: W'(64'h0123_4567_89AB_CDEF), b: W'(64'h1111_1111_1111_1111),
                       cin: 1'b1, sub: 1'b0, s: W'(64'h1234_5678_9ABC_DF01), co: 1'b0});
`ifdef WIDE_ADD_SUB_EN
        vq.push_back('{a: W'(5), b: W'(7), cin: 1'b0, sub: 1'b1, s: ones - W'(1), co: 1'b0});
        vq.push_back('{a: W'(7), b: W'(5), cin: 1'b0, sub: 1'b1, s: W'(2), co: 1'b1});
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", W'(in_ready), W'(0));
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_sum", sum, W'(0));
        chk("reset_cout", W'(cout), W'(0));
        rst = 1'b0;
        #1;
        chk("release_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;

        foreach (vq[i]) begin
            v = vq[i];
            run_op(v.a, v.b, v.cin, v.sub, rs, rc, lat);
            chk($sformatf("vec%0d_sum", i), rs, v.s);
            chk($sformatf("vec%0d_cout", i), W'(rc), W'(v.co));
            chk($sformatf("vec%0d_latency", i), W'(lat), W'(4));
        end

        // Backpressure: new request waits while the result is held.
        a = W'(5); b = W'(6); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = W'(10); b = W'(20); cin = 1'b0;
        wait_out(lat);
        chk("bp_first_latency", W'(lat), W'(4));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold%0d_sum", i), sum, W'(11));
            chk($sformatf("bp_hold%0d_cout", i), W'(cout), W'(0));
            chk($sformatf("bp_hold%0d_in_ready", i), W'(in_ready), W'(0));
            chk($sformatf("bp_hold%0d_out_valid", i), W'(out_valid), W'(1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_out_valid", W'(out_valid), W'(0));
        chk("bp_release_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; a = '1; b = '1; cin = 1'b1;
        chk("bp_accepted_in_ready", W'(in_ready), W'(0));
        wait_out(lat);
        chk("bp_second_latency", W'(lat), W'(4));
        chk("bp_second_sum", sum, W'(30));
        chk("bp_second_cout", W'(cout), W'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in RUN after slice 2 has been written.
        a = ones; b = ones; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pre_sum_nonzero", W'(sum != '0), W'(1));
        rst = 1'b1;
        #1;
        chk("abort_out_valid", W'(out_valid), W'(0));
        chk("abort_sum", sum, W'(0));
        chk("abort_cout", W'(cout), W'(0));
        chk("abort_in_ready", W'(in_ready), W'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(W'(3), W'(4), 1'b0, 1'b0, rs, rc, lat);
        chk("post_reset_sum", rs, W'(7));
        chk("post_reset_cout", W'(rc), W'(0));
        chk("post_reset_latency", W'(lat), W'(4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
